// File: rtl/seg_seq_pkg.sv
// Shared definitions for the segment fade sequencer: FSM encoding,
// segment pattern table and the broadcast segment index.
package seg_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } seq_state_t;

    // Segment index that addresses all seven segments at once.
    localparam logic [2:0] SEG_BROADCAST = 3'd7;

    // Width of the pattern pointer; the longest pattern has 8 entries.
    localparam int PTR_W = 3;

    // Pattern lengths expressed as the last valid pointer value (L-1).
    function automatic logic [PTR_W-1:0] pattern_last(input logic [1:0] pat);
        logic [PTR_W-1:0] last;
        case (pat)
            2'd0:    last = 3'd7;   // figure-8, L=8
            2'd1:    last = 3'd5;   // circle,   L=6
            2'd2:    last = 3'd6;   // sweep,    L=7
            default: last = 3'd0;   // blink-all, L=1
        endcase
        return last;
    endfunction

    // Pattern ROM: segment index for a given pattern and pointer.
    function automatic logic [2:0] pattern_seg(input logic [1:0] pat,
                                               input logic [PTR_W-1:0] ptr);
        logic [2:0] seg;
        seg = 3'd0;
        case (pat)
            2'd0: begin
                case (ptr)
                    3'd0:    seg = 3'd0;
                    3'd1:    seg = 3'd1;
                    3'd2:    seg = 3'd6;
                    3'd3:    seg = 3'd4;
                    3'd4:    seg = 3'd3;
                    3'd5:    seg = 3'd2;
                    3'd6:    seg = 3'd6;
                    default: seg = 3'd5;
                endcase
            end
            2'd1:    seg = (ptr <= 3'd5) ? ptr : 3'd0;
            2'd2:    seg = (ptr <= 3'd6) ? ptr : 3'd0;
            default: seg = SEG_BROADCAST;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_seq_step_timer.sv
// Step-rate timer: counts while enabled and pulses for one cycle each time
// the count reaches the period derived from the registered speed code.
module seg_seq_step_timer
    import seg_seq_pkg::*;
#(
    parameter int TIMER_W     = 24,
    parameter int SPEED_SHIFT = 21
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [2:0] speed,
    output logic       step
);

    logic [TIMER_W-1:0] timer_reg;
    logic [TIMER_W-1:0] period;

    // Faster speed codes shorten the period; the low bits are always ones.
    assign period = TIMER_W'({~speed, {SPEED_SHIFT{1'b1}}});

    // Comparing with >= lets a lowered period take effect immediately.
    assign step = enable && (timer_reg >= period);

    // Timer register: cleared while disabled and on every step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_reg <= '0;
        end else if (!enable || step) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/seg_fade_sequencer.sv
// Segment fade sequencer: walks a segment pattern at a programmable step
// rate, issues one full-brightness load per step over valid/ready and
// emits the periodic fade tick.
// Optional build macro SEG_SEQ_BOUNCE_EN: ping-pong walking instead of wrap.
module seg_fade_sequencer
    import seg_seq_pkg::*;
#(
    parameter int TIMER_W     = 24,
    parameter int SPEED_SHIFT = 21,
    parameter int FADE_W      = 21,
    parameter int LEVEL_W     = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_run,
    input  logic [2:0]         cfg_speed,
    input  logic               cfg_dir,
    input  logic [1:0]         cfg_pattern,
    output logic               seg_valid,
    input  logic               seg_ready,
    output logic [2:0]         seg_idx,
    output logic [LEVEL_W-1:0] seg_level,
    output logic               fade_tick,
    output logic               overrun
);

    seq_state_t        state_reg, state_next;
    logic [2:0]        speed_reg;
    logic [PTR_W-1:0]  ptr_reg, ptr_next;
    logic [1:0]        pat_reg, pat_next;
    logic              dir_reg, dir_next;
    logic [FADE_W-1:0] fade_cnt_reg;
    logic              fade_tick_reg;
    logic              overrun_reg;
    logic              step;
    logic              xfer;
    logic [PTR_W-1:0]  pat_last;

`ifdef SEG_SEQ_BOUNCE_EN
    // Direction comes from the pattern ends, so the input is not needed.
    logic unused_cfg_dir;
    assign unused_cfg_dir = cfg_dir;
`endif

    seg_seq_step_timer #(
        .TIMER_W    (TIMER_W),
        .SPEED_SHIFT(SPEED_SHIFT)
    ) u_step_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (state_reg != ST_IDLE),
        .speed  (speed_reg),
        .step   (step)
    );

    assign seg_valid = (state_reg == ST_ISSUE);
    assign xfer      = seg_valid && seg_ready;
    assign pat_last  = pattern_last(pat_reg);
    assign seg_idx   = seg_valid ? pattern_seg(pat_reg, ptr_reg) : 3'd0;
    assign seg_level = '1;
    assign fade_tick = fade_tick_reg;
    assign overrun   = overrun_reg;

    // State, pointer and sampled configuration registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            speed_reg <= 3'd0;
            ptr_reg   <= '0;
            pat_reg   <= 2'd0;
            dir_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            speed_reg <= cfg_speed;
            ptr_reg   <= ptr_next;
            pat_reg   <= pat_next;
            dir_reg   <= dir_next;
        end
    end

    // Next-state, pointer advance on transfer, pattern/direction sampling on step.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        pat_next   = pat_reg;
        dir_next   = dir_reg;

        if (xfer) begin
`ifdef SEG_SEQ_BOUNCE_EN
            if (dir_reg) begin
                if (ptr_reg == pat_last) begin
                    ptr_next = (pat_last == '0) ? '0 : ptr_reg - 3'd1;
                    dir_next = 1'b0;
                end else begin
                    ptr_next = ptr_reg + 3'd1;
                end
            end else begin
                if (ptr_reg == '0) begin
                    ptr_next = (pat_last == '0) ? '0 : 3'd1;
                    dir_next = 1'b1;
                end else begin
                    ptr_next = ptr_reg - 3'd1;
                end
            end
`else
            if (dir_reg) begin
                ptr_next = (ptr_reg == pat_last) ? '0 : ptr_reg + 3'd1;
            end else begin
                ptr_next = (ptr_reg == '0) ? pat_last : ptr_reg - 3'd1;
            end
`endif
        end

        if (!cfg_run) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_WAIT;
                ST_WAIT: begin
                    if (step) begin
                        state_next = ST_ISSUE;
                        if (cfg_pattern != pat_reg) begin
                            pat_next = cfg_pattern;
                            ptr_next = '0;
`ifdef SEG_SEQ_BOUNCE_EN
                            dir_next = 1'b1;
`endif
                        end
`ifndef SEG_SEQ_BOUNCE_EN
                        dir_next = cfg_dir;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (xfer) begin
                        state_next = ST_WAIT;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Fade counter: free-running outside IDLE, tick on the cycle it wraps to zero.
    always_ff @(posedge clk) begin
        if (!reset_n || state_reg == ST_IDLE) begin
            fade_cnt_reg  <= '0;
            fade_tick_reg <= 1'b0;
        end else begin
            fade_cnt_reg  <= fade_cnt_reg + FADE_W'(1);
            fade_tick_reg <= (fade_cnt_reg == '1);
        end
    end

    // Sticky overrun: a step expired while a command was still waiting for ready.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overrun_reg <= 1'b0;
        end else if (seg_valid && step && !seg_ready) begin
            overrun_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_fade_sequencer.sv
// Self-checking bench for seg_fade_sequencer: directed steps followed by a
// randomized run, all compared against a behavioural model of the sequencer.
module tb_seg_fade_sequencer;

    localparam int TIMER_W     = 8;
    localparam int SPEED_SHIFT = 2;
    localparam int FADE_W      = 4;
    localparam int LEVEL_W     = 5;
    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_ISSUE = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               cfg_run;
    logic [2:0]         cfg_speed;
    logic               cfg_dir;
    logic [1:0]         cfg_pattern;
    logic               seg_valid;
    logic               seg_ready;
    logic [2:0]         seg_idx;
    logic [LEVEL_W-1:0] seg_level;
    logic               fade_tick;
    logic               overrun;

    always #5 clk = ~clk;

    seg_fade_sequencer #(
        .TIMER_W    (TIMER_W),
        .SPEED_SHIFT(SPEED_SHIFT),
        .FADE_W     (FADE_W),
        .LEVEL_W    (LEVEL_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_run    (cfg_run),
        .cfg_speed  (cfg_speed),
        .cfg_dir    (cfg_dir),
        .cfg_pattern(cfg_pattern),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .seg_idx    (seg_idx),
        .seg_level  (seg_level),
        .fade_tick  (fade_tick),
        .overrun    (overrun)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    int pat_tab[4][8];
    int pat_len[4];

    // Behavioural model state
    int m_state, m_timer, m_speed, m_ptr, m_pat, m_dir, m_fcnt;
    bit m_tick, m_ovr;

    int   xfer_q[$];
    int   vrise_q[$];
    int   tick_q[$];
    logic prev_valid = 1'b0;
    int   held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic int period_of(input int spd);
        return (8 - spd) * (1 << SPEED_SHIFT) - 1;
    endfunction

    // Pointer movement on an accepted command.
    task automatic model_advance_ptr();
        int len;
        len = pat_len[m_pat];
`ifdef SEG_SEQ_BOUNCE_EN
        if (m_dir == 1) begin
            if (m_ptr + 1 < len) m_ptr = m_ptr + 1;
            else begin m_dir = 0; m_ptr = (len > 1) ? len - 2 : 0; end
        end else begin
            if (m_ptr > 0) m_ptr = m_ptr - 1;
            else begin m_dir = 1; m_ptr = (len > 1) ? 1 : 0; end
        end
`else
        if (m_dir == 1) m_ptr = (m_ptr + 1) % len;
        else            m_ptr = (m_ptr + len - 1) % len;
`endif
    endtask

    // Predict what the sequencer looks like after the coming clock edge.
    task automatic model_edge();
        bit active, step, xfer;
        if (!reset_n) begin
            m_state = M_IDLE; m_timer = 0; m_speed = 0; m_ptr = 0; m_pat = 0;
            m_dir = 1; m_fcnt = 0; m_tick = 0; m_ovr = 0;
            return;
        end
        active = (m_state != M_IDLE);
        step   = active && (m_timer >= period_of(m_speed));
        xfer   = (m_state == M_ISSUE) && seg_ready;
        if (m_state == M_ISSUE && step && !seg_ready) m_ovr = 1;
        m_tick  = active && (m_fcnt == (1 << FADE_W) - 1);
        m_fcnt  = active ? (m_fcnt + 1) % (1 << FADE_W) : 0;
        m_timer = (!active || step) ? 0 : m_timer + 1;
        m_speed = int'(cfg_speed);
        if (xfer) model_advance_ptr();
        if (!cfg_run) m_state = M_IDLE;
        else if (m_state == M_IDLE) m_state = M_WAIT;
        else if (m_state == M_WAIT && step) begin
            if (int'(cfg_pattern) != m_pat) begin
                m_pat = int'(cfg_pattern);
                m_ptr = 0;
`ifdef SEG_SEQ_BOUNCE_EN
                m_dir = 1;
`endif
            end
`ifndef SEG_SEQ_BOUNCE_EN
            m_dir = int'(cfg_dir);
`endif
            m_state = M_ISSUE;
        end else if (m_state == M_ISSUE && xfer) m_state = M_WAIT;
    endtask

    // One clock: log transfers, advance model, then compare every output.
    task automatic cyc();
        int exp_idx;
        if (seg_valid === 1'b1 && seg_ready === 1'b1) begin
            xfer_q.push_back(int'(seg_idx));
            $display("xfer cycle=%0d idx=%0d", cyc_n, seg_idx);
        end
        model_edge();
        @(posedge clk);
        #1;
        cyc_n++;
        exp_idx = (m_state == M_ISSUE) ? pat_tab[m_pat][m_ptr] : 0;
        chk("valid",     32'(seg_valid), 32'(m_state == M_ISSUE));
        chk("idx",       32'(seg_idx),   32'(exp_idx));
        chk("level",     32'(seg_level), 32'h1F);
        chk("fade_tick", 32'(fade_tick), 32'(m_tick));
        chk("overrun",   32'(overrun),   32'(m_ovr));
        if (seg_valid === 1'b1 && prev_valid !== 1'b1) vrise_q.push_back(cyc_n);
        if (fade_tick === 1'b1) tick_q.push_back(cyc_n);
        prev_valid = seg_valid;
    endtask

    task automatic collect(input int n, input int max_cycles);
        for (int i = 0; i < max_cycles && xfer_q.size() < n; i++) cyc();
    endtask

    task automatic check_seq(input string tag, input int exp_q[$]);
        chk({tag, "_len"}, 32'(xfer_q.size() >= exp_q.size()), 32'd1);
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, (i < xfer_q.size()) ? 32'(xfer_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    initial begin
        pat_tab[0] = '{0, 1, 6, 4, 3, 2, 6, 5};
        pat_tab[1] = '{0, 1, 2, 3, 4, 5, 0, 0};
        pat_tab[2] = '{0, 1, 2, 3, 4, 5, 6, 0};
        pat_tab[3] = '{7, 0, 0, 0, 0, 0, 0, 0};
        pat_len    = '{8, 6, 7, 1};

        // Step 1: reset held with run requested
        reset_n = 1'b0; cfg_run = 1'b1; cfg_speed = 3'd7; cfg_dir = 1'b1;
        cfg_pattern = 2'd0; seg_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("reset_valid", 32'(seg_valid), 32'd0);
        end

        // Step 2: figure-8 forward, ready tied high
        reset_n = 1'b1;
        xfer_q.delete(); vrise_q.delete(); tick_q.delete();
        for (int i = 0; i < 200 && (xfer_q.size() < 9 || i < 50); i++) cyc();
`ifdef SEG_SEQ_BOUNCE_EN
        check_seq("fig8_seq", '{0, 1, 6, 4, 3, 2, 6, 5, 6});
`else
        check_seq("fig8_seq", '{0, 1, 6, 4, 3, 2, 6, 5, 0});
`endif
        for (int i = 1; i < vrise_q.size(); i++)
            chk("valid_gap", 32'(vrise_q[i] - vrise_q[i-1]), 32'd4);
        chk("tick_seen", 32'(tick_q.size() >= 2), 32'd1);
        for (int i = 1; i < tick_q.size(); i++)
            chk("tick_gap", 32'(tick_q[i] - tick_q[i-1]), 32'd16);

        // Step 3: circle pattern, reverse
        cfg_run = 1'b0; cyc();
        cfg_pattern = 2'd1; cfg_dir = 1'b0; cfg_run = 1'b1;
        xfer_q.delete();
        collect(8, 200);
`ifndef SEG_SEQ_BOUNCE_EN
        check_seq("circle_rev", '{0, 5, 4, 3, 2, 1, 0, 5});
`endif

        // Step 4: stall ready across two step periods
        seg_ready = 1'b0;
        for (int i = 0; i < 50 && seg_valid !== 1'b1; i++) cyc();
        chk("stall_valid_seen", 32'(seg_valid), 32'd1);
        held = pat_tab[m_pat][m_ptr];
        for (int i = 0; i < 9; i++) cyc();
        chk("stall_valid", 32'(seg_valid), 32'd1);
        chk("stall_idx",   32'(seg_idx),   32'(held));
        chk("stall_ovr",   32'(overrun),   32'd1);

        // Step 5: drop run mid-issue, then re-run re-issues the same segment
        cfg_run = 1'b0; cyc();
        chk("drop_valid", 32'(seg_valid), 32'd0);
        cfg_run = 1'b1; seg_ready = 1'b1;
        xfer_q.delete();
        collect(1, 100);
        check_seq("reissue", '{held});

`ifdef SEG_SEQ_BOUNCE_EN
        // Sweep pattern ping-pong
        cfg_run = 1'b0; cyc();
        cfg_pattern = 2'd2; cfg_run = 1'b1;
        xfer_q.delete();
        collect(14, 300);
        check_seq("bounce_sweep", '{0, 1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 1});
`endif

        // Step 6: randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            seg_ready = ($urandom_range(0, 9) < 7);
            cfg_run   = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 36) == 0) cfg_pattern = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) cfg_dir     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) cfg_speed   = 3'($urandom_range(4, 7));
            reset_n = !(i >= 400 && i < 402);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
